// File: rtl/beep_pkg.sv
// Shared constants for the note player: note periods, FSM encoding, beat timing.
package beep_pkg;

  localparam int PERIOD_W = 20;
  localparam int BEATS_W  = 4;
  localparam int NOTE_W   = PERIOD_W + BEATS_W;

  localparam logic [23:0] TIME_125MS_DEF = 24'd12499999;
  localparam logic [23:0] GAP_CYCLES_DEF = 24'd1249999;

  // Tone periods in 100 MHz clock cycles.
  localparam logic [PERIOD_W-1:0] NOTE_REST = 20'd0;
  localparam logic [PERIOD_W-1:0] NOTE_C4   = 20'd382219;
  localparam logic [PERIOD_W-1:0] NOTE_D4   = 20'd340530;
  localparam logic [PERIOD_W-1:0] NOTE_E4   = 20'd303370;
  localparam logic [PERIOD_W-1:0] NOTE_F4   = 20'd286344;
  localparam logic [PERIOD_W-1:0] NOTE_G4   = 20'd255102;
  localparam logic [PERIOD_W-1:0] NOTE_A4   = 20'd227273;
  localparam logic [PERIOD_W-1:0] NOTE_B4   = 20'd202478;
  localparam logic [PERIOD_W-1:0] NOTE_C5   = 20'd191113;
  localparam logic [PERIOD_W-1:0] NOTE_D5   = 20'd170262;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [BEATS_W-1:0]  beats;
  } note_t;

  // Periods 0 and 1 cannot form a square wave; treat them as silence.
  function automatic logic is_rest(input logic [PERIOD_W-1:0] period);
    return period < 20'd2;
  endfunction

endpackage

// File: rtl/beep_note_player_if.sv
// Note command handshake between a producer and the note player.
interface beep_note_player_if;
  import beep_pkg::*;

  logic                note_valid;
  logic                note_ready;
  logic [PERIOD_W-1:0] note_period;
  logic [BEATS_W-1:0]  note_beats;

  modport master (
    output note_valid,
    output note_period,
    output note_beats,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_period,
    input  note_beats,
    output note_ready
  );

endinterface

// File: rtl/beep_note_fifo.sv
// Note command buffer: synchronous FIFO with first-word fall-through read.
module beep_note_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign rdata = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign level = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/beep_note_player.sv
// Buffered square-wave note player for a piezo buzzer.
// Define BEEP_GAP_EN to insert a silent gap after every played note.
module beep_note_player
  import beep_pkg::*;
#(
  parameter logic [23:0] TIME_125MS = TIME_125MS_DEF,
  parameter logic [23:0] GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  beep_note_player_if.slave   bus,
  input  logic                mute,
  output logic                busy,
  output logic                beep
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  note_t         head;
  note_t         wnote;

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [PERIOD_W-1:0] period;
  logic [BEATS_W-1:0]  beats_left;
  logic [23:0]         beat_cnt;
  logic [PERIOD_W-1:0] tone_cnt;

  logic beat_wrap;
  logic play_exit;
  logic tone_wrap;
  logic tone_hi;
  logic more;
  logic beep_nx;

  assign bus.note_ready = !fifo_full;
  assign push  = bus.note_valid && !fifo_full;
  assign pop   = state == ST_LOAD;
  assign wnote = '{period: bus.note_period, beats: bus.note_beats};

  beep_note_fifo #(
    .WIDTH (NOTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wnote),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A push landing in the decision cycle counts, so notes chain without an idle slot.
  assign more      = !fifo_empty || push;
  assign beat_wrap = beat_cnt == TIME_125MS;
  assign play_exit = beat_wrap && beats_left == 4'd1;
  assign tone_wrap = is_rest(period) || tone_cnt == period - 20'd1;
  assign tone_hi   = tone_cnt >= (period >> 1);

  assign beep_nx = state == ST_PLAY && !play_exit &&
                   !is_rest(period) && !mute && tone_hi;

  assign busy = state != ST_IDLE || !fifo_empty;

`ifdef BEEP_GAP_EN
  logic [23:0] gap_cnt;
  logic        gap_done;

  assign gap_done = gap_cnt == GAP_CYCLES;

  always_ff @(posedge clk) begin
    if (rst)
      gap_cnt <= '0;
    else if (state == ST_GAP && !gap_done)
      gap_cnt <= gap_cnt + 24'd1;
    else
      gap_cnt <= '0;
  end
`else
  logic unused_gap;
  assign unused_gap = ^GAP_CYCLES;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty)
          state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (head.beats != '0)
          state_nx = ST_PLAY;
        else if (fifo_level > LW'(1) || push)
          state_nx = ST_LOAD;
        else
          state_nx = ST_IDLE;
      end
      ST_PLAY: begin
        if (play_exit) begin
`ifdef BEEP_GAP_EN
          state_nx = ST_GAP;
`else
          state_nx = more ? ST_LOAD : ST_IDLE;
`endif
        end
      end
      ST_GAP: begin
`ifdef BEEP_GAP_EN
        if (gap_done)
          state_nx = more ? ST_LOAD : ST_IDLE;
`else
        state_nx = ST_IDLE;
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      period     <= '0;
      beats_left <= '0;
      beat_cnt   <= '0;
      tone_cnt   <= '0;
      beep       <= 1'b0;
    end else begin
      state <= state_nx;
      beep  <= beep_nx;
      unique case (1'b1)
        state == ST_LOAD: begin
          period     <= head.period;
          beats_left <= head.beats;
          beat_cnt   <= '0;
          tone_cnt   <= '0;
        end
        state == ST_PLAY: begin
          beat_cnt <= beat_wrap ? '0 : beat_cnt + 24'd1;
          tone_cnt <= tone_wrap ? '0 : tone_cnt + 20'd1;
          if (beat_wrap)
            beats_left <= beats_left - 4'd1;
        end
        default: begin
          beat_cnt <= beat_cnt;
        end
      endcase
    end
  end

endmodule
